// File: rtl/regfile_pkg.sv
// Shared register-file writeback types: index/data widths, request struct, grant encoding.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } wb_grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and the register-file write port.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = regfile_pkg::XLEN,
    parameter int ADDR_W = regfile_pkg::REG_ADDR_W
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter_prio_grant.sv
// LSU-priority grant with a saturating ALU starvation counter that forces an ALU win.
module wb_prio_grant
    import regfile_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       alu_valid,
    input  logic       lsu_valid,
    output wb_grant_e  grant,
    output logic [3:0] starve_cnt
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;

    // Grant is suppressed during reset so neither requester sees ready.
    always_comb begin
        grant = GNT_NONE;
        if (!rst_n) begin
            grant = GNT_NONE;
        end else if (alu_valid && lsu_valid) begin
            grant = (starve_cnt_reg == STARVE_LIM) ? GNT_ALU : GNT_LSU;
        end else if (alu_valid) begin
            grant = GNT_ALU;
        end else if (lsu_valid) begin
            grant = GNT_LSU;
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (flush || grant == GNT_ALU) begin
            starve_cnt_next = 4'd0;
        end else if (alu_valid && starve_cnt_reg < STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign starve_cnt = starve_cnt_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ALU/LSU writeback arbiter feeding a registered register-file write port.
// Optional operand forwarding from the write port is enabled by REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = XLEN,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    regfile_wb_arbiter_if.slave   bus,
`ifdef REGFILE_WB_FWD_EN
    input  logic [ADDR_W-1:0]     rs1,
    input  logic [ADDR_W-1:0]     rs2,
    output logic                  fwd1_hit,
    output logic [DATA_W-1:0]     fwd1_data,
    output logic                  fwd2_hit,
    output logic [DATA_W-1:0]     fwd2_data,
`endif
    output logic [3:0]            starve_cnt
);
    wb_grant_e         grant;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              rf_we_reg;
    logic [ADDR_W-1:0] rf_rd_reg;
    logic [DATA_W-1:0] rf_wdata_reg;

    wb_prio_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .alu_valid  (bus.alu_valid),
        .lsu_valid  (bus.lsu_valid),
        .grant      (grant),
        .starve_cnt (starve_cnt)
    );

    assign bus.alu_ready = (grant == GNT_ALU);
    assign bus.lsu_ready = (grant == GNT_LSU);

    always_comb begin
        sel_rd   = bus.lsu_rd;
        sel_data = bus.lsu_data;
        if (grant == GNT_ALU) begin
            sel_rd   = bus.alu_rd;
            sel_data = bus.alu_data;
        end
    end

    // Writes to x0 still consume the request and update index/data, but never assert we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_reg    <= 1'b0;
            rf_rd_reg    <= '0;
            rf_wdata_reg <= '0;
        end else begin
            rf_we_reg <= 1'b0;
            if (grant != GNT_NONE && !flush) begin
                rf_we_reg    <= (sel_rd != '0);
                rf_rd_reg    <= sel_rd;
                rf_wdata_reg <= sel_data;
            end
        end
    end

    assign bus.rf_we    = rf_we_reg;
    assign bus.rf_rd    = rf_rd_reg;
    assign bus.rf_wdata = rf_wdata_reg;

`ifdef REGFILE_WB_FWD_EN
    assign fwd1_hit  = rf_we_reg && (rf_rd_reg == rs1) && (rs1 != '0);
    assign fwd2_hit  = rf_we_reg && (rf_rd_reg == rs2) && (rs2 != '0);
    assign fwd1_data = rf_wdata_reg;
    assign fwd2_data = rf_wdata_reg;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / rd / wr_data) between two writeback requesters: ALU and LSU.
- Each requester uses a valid/ready handshake. The winner is captured into a one-entry output register that drives the register file the next cycle.
- Sits between the execute/memory stages and the register file.
- Fixed priority to LSU, with an anti-starvation counter that guarantees ALU progress.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register index width.
- STARVE_MAX, 4, consecutive cycles ALU may be denied before it is forced to win (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drops the output register contents and zeroes the starvation counter.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  ADDR_W  LSU destination register.
- lsu_data  in  DATA_W  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  ADDR_W  register-file write index (registered).
- rf_wdata  out  DATA_W  register-file write data (registered).
- starve_cnt  out  4  current ALU denial count (debug).

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, starve_cnt=0. alu_ready and lsu_ready are 0 while rst_n=0.
- Readiness: the register file accepts a write every cycle, so the arbiter never back-pressures globally. Exactly the granted requester sees ready=1.
  - Ready is combinational from the valids and starve_cnt.
  - A transfer occurs when valid && ready.
- Grant rule, evaluated each cycle:
  - If only one requester is valid, it wins.
  - If both are valid: ALU wins when starve_cnt == STARVE_MAX, otherwise LSU wins.
  - If neither is valid, there is no grant.
- Starvation counter:
  - +1 each cycle that alu_valid=1 and ALU is not granted. Saturates at STARVE_MAX.
  - Cleared on an ALU grant or on flush.
  - Held when alu_valid=0.
- Latency: an accepted request in cycle N appears on rf_we/rf_rd/rf_wdata in cycle N+1, held for exactly one cycle.
  - With no accept in cycle N, rf_we=0 in N+1; rf_rd and rf_wdata hold their last values.
- x0 writes: a request with rd=0 is accepted (ready=1, counts as a grant) but rf_we stays 0 in N+1. rf_rd and rf_wdata still update.
- Same rd from both requesters in one cycle: only the winner is accepted. The loser stays valid (it must hold its inputs) and commits later.
  - Final register value = the later commit. Ordering is the requesters' responsibility.
- Flush:
  - rf_we=0 on the next cycle. Any same-cycle accept is discarded, although ready is still asserted, so the requester treats the request as consumed.
  - starve_cnt goes to 0.
- Reset mid-operation: everything clears immediately (asynchronous). Pending requester data is not retained.
- Requester contract: valid must remain asserted with stable rd/data until ready. The arbiter is not required to tolerate withdrawal; the bench flags it.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined: adds ports rs1, rs2 (in, ADDR_W) and, per source, fwd1_hit / fwd2_hit (out, 1) and fwd1_data / fwd2_data (out, DATA_W).
  - fwdN_hit = rf_we && (rf_rd == rsN) && (rsN != 0), combinational. fwdN_data = rf_wdata.
  - This covers a same-cycle read of a value being written, since the register file updates on the clock edge.
- Undefined: these ports are absent and there is no compare logic.

Decomposition:
- Shared package regfile_pkg:
  - Constants: REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0.
  - Typedef wb_req_t (struct: valid, rd, data).
  - Typedef wb_grant_e (enum: GNT_NONE, GNT_ALU, GNT_LSU).
- One natural sub-module, wb_prio_grant: the combinational grant logic plus the saturating starvation counter, driving the grant enum. The top module holds the output register and the optional forwarding.

Test Plan:
- Reset: hold rst_n=0 with both valids=1 -> both readies 0, rf_we=0, starve_cnt=0. Release -> LSU granted on the first clk.
- Single ALU: alu_valid=1, rd=7, data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_rd=7, rf_wdata=0xDEADBEEF; cycle after, rf_we=0.
- Starvation: both valid continuously, STARVE_MAX=4 -> LSU wins 4 cycles (starve_cnt 1,2,3,4), ALU wins cycle 5, starve_cnt returns to 0, pattern repeats.
- x0: lsu_valid=1, rd=0, data=0x1234 -> lsu_ready=1; next cycle rf_we=0.
- Same rd: ALU rd=3 data=0xA and LSU rd=3 data=0xB in the same cycle -> LSU commits 0xB first, then ALU commits 0xA; register 3 ends at 0xA.
- Flush/async reset: accept LSU rd=9 with flush=1 -> rf_we=0 next cycle. Then accept rd=9 and drop rst_n mid-cycle -> rf_we=0 immediately, no write.
